ifid_decode_queue: RTL and testbench
====================================

Name: ifid_decode_queue

Overview:
- Parametrised IF/ID stage between fetch and register-read.
- Replaces the single-entry negedge IF/ID register with a DEPTH-entry FIFO on the rising edge, using valid/ready handshakes on both sides.
- Adds synchronous flush (branch/jump redirect) and an illegal-opcode flag.
- Each instruction is decoded into fields and control flags at push time and stored decoded.

Parameters:
- INSTR_W, 48, instruction width; opcode is the top OPC_W bits.
- PC_W, 48, width of the PC+1 value carried alongside each instruction.
- OPC_W, 6, opcode field width.
- REG_W, 5, register specifier width.
- IMM_W, 32, immediate width, taken from instr[IMM_W-1:0].
- DEPTH, 4, queue entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept (= !full).
- instruction  in  INSTR_W  fetched word.
- pc1  in  PC_W  PC+1 of the fetched word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode stage consumes the head.
- opcode  out  OPC_W  instr[INSTR_W-1 -: OPC_W].
- rd  out  REG_W  the REG_W bits below opcode.
- rs  out  REG_W  the REG_W bits below rd.
- rt  out  REG_W  the REG_W bits below rs.
- immediate  out  IMM_W  instr[IMM_W-1:0].
- flagsDECO  out  1  read-register enable.
- flagsALU  out  4  {main_ALU, opALU[2:0]}.
- flagsMEM  out  3  {zero_ALU, memRD, memWR}.
- flagsWB  out  2  {write_on_reg, sel_dat}.
- illegal  out  1  head opcode not in the decode table.
- pc1_out  out  PC_W  PC+1 of the head entry.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits; pointers wrap modulo DEPTH; count tracks occupancy in 0..DEPTH.
- Push: in_valid && in_ready at a rising edge. The entry is decoded at write time and stored as {fields, flags, illegal, pc1}.
- Pop: out_valid && out_ready at a rising edge.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- in_ready = (count != DEPTH). No push when full, even if a pop occurs in the same cycle.
- Outputs are driven directly from the head entry's stored registers; there is no combinational path from instruction to outputs.
- Latency: a push into an empty queue at edge N gives out_valid=1 after edge N. Throughput is 1 per cycle.
- Empty queue: out_valid=0 and all outputs show bubble values: opcode/rd/rs/rt/immediate/pc1_out=0, flagsDECO=0, flagsALU=0, flagsMEM=000, flagsWB=01, illegal=0.
- Decode table, as {DECO, ALU, MEM, WB}, hex opcodes:
  - 0B ADDI {1,8,000,11}
  - 10 XOR {1,3,000,11}; 11 SRL {1,4,000,11}; 12 SLL {1,5,000,11}; 13 SRC {1,6,000,11}; 14 SLC {1,7,000,11}
  - 15 ADDIV {1,1,000,11}; 16 SUBIV {1,2,000,11}
  - 20 J {0,8,000,01}; 21 NOP {0,0,000,01}
  - 22 BNE {1,0,000,01}; 23 BEQ {1,0,000,01}
  - 24 LV {1,8,010,10}; 25 SV {1,8,001,01}
  - Any other opcode: {0,0,000,01} with illegal=1.
- Flush: synchronous. At the edge it clears count and both pointers, and any concurrent push or pop is discarded. out_valid=0 and in_ready=1 after that edge.
- Flush takes priority over push and pop in the same cycle.
- Reset (rst_n=0, asynchronous, any time including mid-operation): pointers and count are 0, so out_valid=0, in_ready=1 and outputs show bubble values. Entry contents are don't-care.
- Outputs hold stable while out_valid=1 && out_ready=0 (stall), regardless of pushes.
- in_ready does not depend on out_ready combinationally.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, flagsWB=01, all other outputs 0.
- Push ADDI {0x0B, rd=3, rs=1, imm=0x00000005}, pc1=0x10, out_ready=1 -> next cycle out_valid=1, flagsALU=8, flagsWB=11, rd=3, pc1_out=0x10; popped the following edge, count returns to 0.
- With out_ready=0, push DEPTH=4 words (opcodes 10,11,24,25) -> in_ready=0 and count=4. A 5th push is refused. Head holds XOR (flagsALU=3) stable. Draining yields 3,4,{8,010,10},{8,001,01} in order with pointer wrap.
- Full queue with in_valid=1 and out_ready=1 for 3 cycles -> pops only, no push while full; count goes 4->3, then push+pop keeps it at 3.
- Two entries queued, flush asserted together with in_valid and out_ready -> next cycle count=0, out_valid=0, and the pushed word is absent.
- Push opcode 0x3F -> illegal=1, flags {0,0,000,01}. Then assert rst_n=0 asynchronously mid-stream -> out_valid drops immediately and count=0.

Source files
------------

// File: rtl/ifid_decode_queue.sv
// IF/ID stage: a DEPTH-entry queue of pre-decoded instructions between fetch and register-read.
// Decoding happens at push time, so the head outputs come straight from stored registers.
module ifid_decode_queue #(
   parameter int INSTR_W = 48,
   parameter int PC_W    = 48,
   parameter int OPC_W   = 6,
   parameter int REG_W   = 5,
   parameter int IMM_W   = 32,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INSTR_W-1:0]         instruction,
   input  logic [PC_W-1:0]            pc1,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OPC_W-1:0]           opcode,
   output logic [REG_W-1:0]           rd,
   output logic [REG_W-1:0]           rs,
   output logic [REG_W-1:0]           rt,
   output logic [IMM_W-1:0]           immediate,
   output logic                       flagsDECO,
   output logic [3:0]                 flagsALU,
   output logic [2:0]                 flagsMEM,
   output logic [1:0]                 flagsWB,
   output logic                       illegal,
   output logic [PC_W-1:0]            pc1_out,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [IMM_W-1:0] imm;
      logic             deco;
      logic [3:0]       alu;
      logic [2:0]       mem;
      logic [1:0]       wb;
      logic             illegal;
      logic [PC_W-1:0]  pc1;
   } entry_t;

   entry_t            entry_mem [DEPTH];
   entry_t            wr_entry;
   entry_t            head;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              push, pop;

   assign in_ready  = (count_reg != CNT_W'(DEPTH));
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_reg;

   always_comb begin
      wr_entry         = '0;
      wr_entry.opcode  = instruction[INSTR_W-1 -: OPC_W];
      wr_entry.rd      = instruction[INSTR_W-OPC_W-1 -: REG_W];
      wr_entry.rs      = instruction[INSTR_W-OPC_W-REG_W-1 -: REG_W];
      wr_entry.rt      = instruction[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
      wr_entry.imm     = instruction[IMM_W-1:0];
      wr_entry.pc1     = pc1;
      wr_entry.deco    = 1'b0;
      wr_entry.alu     = 4'd0;
      wr_entry.mem     = 3'b000;
      wr_entry.wb      = 2'b01;
      wr_entry.illegal = 1'b0;
      case (wr_entry.opcode)
         OPC_W'('h0B): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd8; wr_entry.wb = 2'b11; end
         OPC_W'('h10): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd3; wr_entry.wb = 2'b11; end
         OPC_W'('h11): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd4; wr_entry.wb = 2'b11; end
         OPC_W'('h12): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd5; wr_entry.wb = 2'b11; end
         OPC_W'('h13): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd6; wr_entry.wb = 2'b11; end
         OPC_W'('h14): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd7; wr_entry.wb = 2'b11; end
         OPC_W'('h15): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd1; wr_entry.wb = 2'b11; end
         OPC_W'('h16): begin wr_entry.deco = 1'b1; wr_entry.alu = 4'd2; wr_entry.wb = 2'b11; end
         OPC_W'('h20): begin wr_entry.alu = 4'd8; end
         OPC_W'('h21): ;
         OPC_W'('h22),
         OPC_W'('h23): begin wr_entry.deco = 1'b1; end
         OPC_W'('h24): begin
            wr_entry.deco = 1'b1; wr_entry.alu = 4'd8; wr_entry.mem = 3'b010; wr_entry.wb = 2'b10;
         end
         OPC_W'('h25): begin
            wr_entry.deco = 1'b1; wr_entry.alu = 4'd8; wr_entry.mem = 3'b001;
         end
         default:      wr_entry.illegal = 1'b1;
      endcase
   end

   // Entry storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push && !flush)
         entry_mem[wr_ptr_reg] <= wr_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop)      count_reg <= count_reg + 1'b1;
         else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
   end

   // An empty queue presents a bubble: zero fields and the default WB select.
   always_comb begin
      head = entry_mem[rd_ptr_reg];
      if (!out_valid) begin
         head    = '0;
         head.wb = 2'b01;
      end
   end

   assign opcode    = head.opcode;
   assign rd        = head.rd;
   assign rs        = head.rs;
   assign rt        = head.rt;
   assign immediate = head.imm;
   assign flagsDECO = head.deco;
   assign flagsALU  = head.alu;
   assign flagsMEM  = head.mem;
   assign flagsWB   = head.wb;
   assign illegal   = head.illegal;
   assign pc1_out   = head.pc1;

endmodule

// File: tb/tb_ifid_decode_queue.sv
// Scoreboard bench for ifid_decode_queue: expected decoded entries are queued on push
// and compared against the head outputs whenever the queue presents them.
module tb_ifid_decode_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [5:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] imm;
      logic        deco;
      logic [3:0]  alu;
      logic [2:0]  mem;
      logic [1:0]  wb;
      logic        ill;
      logic [47:0] pc1;
   } exp_t;

   logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic        in_ready, out_valid, flagsDECO, illegal;
   logic [47:0] instruction = '0, pc1 = '0, pc1_out;
   logic [5:0]  opcode;
   logic [4:0]  rd, rs, rt;
   logic [31:0] immediate;
   logic [3:0]  flagsALU;
   logic [2:0]  flagsMEM;
   logic [1:0]  flagsWB;
   logic [2:0]  count;

   int   checks = 0, errors = 0;
   exp_t exp_q[$];
   exp_t cur_exp;
   exp_t act;

   ifid_decode_queue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc1(pc1), .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .immediate(immediate),
      .flagsDECO(flagsDECO), .flagsALU(flagsALU), .flagsMEM(flagsMEM), .flagsWB(flagsWB),
      .illegal(illegal), .pc1_out(pc1_out), .count(count)
   );

   always #5 clk = ~clk;

   function automatic exp_t make_exp(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s,
                                     input logic [31:0] im, input logic [47:0] p);
      exp_t e;
      e = '0;
      e.opc = o; e.rd = d; e.rs = s; e.rt = im[31:27]; e.imm = im; e.pc1 = p;
      e.wb = 2'b01;
      case (o)
         6'h0B: begin e.deco = 1; e.alu = 8; e.wb = 2'b11; end
         6'h10: begin e.deco = 1; e.alu = 3; e.wb = 2'b11; end
         6'h11: begin e.deco = 1; e.alu = 4; e.wb = 2'b11; end
         6'h12: begin e.deco = 1; e.alu = 5; e.wb = 2'b11; end
         6'h13: begin e.deco = 1; e.alu = 6; e.wb = 2'b11; end
         6'h14: begin e.deco = 1; e.alu = 7; e.wb = 2'b11; end
         6'h15: begin e.deco = 1; e.alu = 1; e.wb = 2'b11; end
         6'h16: begin e.deco = 1; e.alu = 2; e.wb = 2'b11; end
         6'h20: begin e.alu = 8; end
         6'h21: ;
         6'h22, 6'h23: e.deco = 1;
         6'h24: begin e.deco = 1; e.alu = 8; e.mem = 3'b010; e.wb = 2'b10; end
         6'h25: begin e.deco = 1; e.alu = 8; e.mem = 3'b001; end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   function automatic exp_t sample_head();
      exp_t h;
      h = {opcode, rd, rs, rt, immediate, flagsDECO, flagsALU, flagsMEM, flagsWB, illegal, pc1_out};
      return h;
   endfunction

   task automatic drive_word(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s,
                             input logic [31:0] im, input logic [47:0] p);
      instruction = {o, d, s, im};
      pc1         = p;
      in_valid    = 1;
      cur_exp     = make_exp(o, d, s, im, p);
   endtask

   // Advance one clock, updating the scoreboard with the handshakes the queue should take.
   task automatic tick();
      bit do_push, do_pop;
      do_push = in_valid && (exp_q.size() != DEPTH);
      do_pop  = out_ready && (exp_q.size() != 0);
      if (flush) exp_q.delete();
      else begin
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(cur_exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      exp_t bubble;
      bubble = '0; bubble.wb = 2'b01;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (in_ready !== 1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      act = sample_head();
      checks++; if (act !== bubble) begin errors++; $display("FAIL reset_bubble got %h want %h", act, bubble); end
      $display("reset: out_valid=%0b in_ready=%0b count=%0d flagsWB=%b", out_valid, in_ready, count, flagsWB);
   endtask

   task automatic test_single();
      out_ready = 1;
      drive_word(6'h0B, 5'd3, 5'd1, 32'h5, 48'h10);
      tick();
      in_valid = 0;
      checks++; if (out_valid !== 1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
      act = sample_head();
      checks++;
      if (exp_q.size() == 0 || act !== exp_q[0]) begin errors++; $display("FAIL single_head got %h", act); end
      checks++; if (flagsALU !== 4'd8 || flagsWB !== 2'b11 || rd !== 5'd3 || pc1_out !== 48'h10) begin
         errors++; $display("FAIL single_fields alu=%0d wb=%b rd=%0d pc=%h want 8 11 3 10", flagsALU, flagsWB, rd, pc1_out);
      end
      $display("single: opcode=%h alu=%0d wb=%b rd=%0d pc1=%h", opcode, flagsALU, flagsWB, rd, pc1_out);
      tick();
      checks++; if (count !== 0 || out_valid !== 0) begin errors++; $display("FAIL single_drain count=%0d valid=%0b want 0 0", count, out_valid); end
   endtask

   task automatic test_fill_drain();
      logic [5:0] opcs [4] = '{6'h10, 6'h11, 6'h24, 6'h25};
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         drive_word(opcs[i], 5'(i + 1), 5'(i + 7), $urandom, 48'h100 + 48'(i));
         tick();
      end
      checks++; if (in_ready !== 0 || count !== 4) begin errors++; $display("FAIL fill_full in_ready=%0b count=%0d want 0 4", in_ready, count); end
      drive_word(6'h14, 5'd9, 5'd9, 32'hDEAD_BEEF, 48'h999);
      tick();
      in_valid = 0;
      checks++; if (count !== 4) begin errors++; $display("FAIL fill_refuse count=%0d want 4", count); end
      act = sample_head();
      checks++; if (flagsALU !== 4'd3 || exp_q.size() == 0 || act !== exp_q[0]) begin
         errors++; $display("FAIL fill_stall_head got alu=%0d head=%h", flagsALU, act);
      end
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         act = sample_head();
         checks++;
         if (out_valid !== 1 || exp_q.size() == 0 || act !== exp_q[0]) begin
            errors++; $display("FAIL drain_%0d valid=%0b got %h", i, out_valid, act);
         end
         $display("drain %0d: opcode=%h alu=%0d mem=%b wb=%b", i, opcode, flagsALU, flagsMEM, flagsWB);
         tick();
      end
      checks++; if (count !== 0) begin errors++; $display("FAIL drain_empty count=%0d want 0", count); end
   endtask

   task automatic test_full_pushpop();
      logic [5:0] fill_opcs [4] = '{6'h15, 6'h16, 6'h12, 6'h13};
      logic [5:0] new_opcs  [3] = '{6'h22, 6'h23, 6'h20};
      int nxt;
      bit accepted;
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         drive_word(fill_opcs[i], 5'(i), 5'(i + 2), 32'h1000 + 32'(i), 48'h200 + 48'(i));
         tick();
      end
      out_ready = 1;
      nxt = 0;
      for (int c = 0; c < 3; c++) begin
         drive_word(new_opcs[nxt], 5'(nxt + 20), 5'(nxt), 32'hA000 + 32'(nxt), 48'h300 + 48'(nxt));
         accepted = (exp_q.size() != DEPTH);
         act = sample_head();
         checks++;
         if (exp_q.size() == 0 || act !== exp_q[0]) begin errors++; $display("FAIL pushpop_head_%0d got %h", c, act); end
         tick();
         if (accepted) nxt++;
         checks++; if (count !== 3) begin errors++; $display("FAIL pushpop_count_%0d got %0d want 3", c, count); end
         $display("pushpop %0d: count=%0d in_ready=%0b", c, count, in_ready);
      end
      in_valid = 0;
      while (exp_q.size() != 0) begin
         act = sample_head();
         checks++;
         if (out_valid !== 1 || act !== exp_q[0]) begin errors++; $display("FAIL pushpop_drain valid=%0b got %h want %h", out_valid, act, exp_q[0]); end
         tick();
      end
      checks++; if (out_valid !== 0) begin errors++; $display("FAIL pushpop_empty valid=%0b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 0;
      for (int i = 0; i < 2; i++) begin
         drive_word(6'h10, 5'(i), 5'(i), 32'(i), 48'h400 + 48'(i));
         tick();
      end
      drive_word(6'h0B, 5'd31, 5'd31, 32'h7777, 48'h4FF);
      flush = 1; out_ready = 1;
      tick();
      flush = 0; in_valid = 0;
      checks++; if (count !== 0 || out_valid !== 0 || in_ready !== 1) begin
         errors++; $display("FAIL flush_clear count=%0d valid=%0b ready=%0b want 0 0 1", count, out_valid, in_ready);
      end
      tick();
      checks++; if (out_valid !== 0 || pc1_out !== 0) begin errors++; $display("FAIL flush_absent valid=%0b pc1=%h want 0 0", out_valid, pc1_out); end
      $display("flush: count=%0d out_valid=%0b", count, out_valid);
   endtask

   task automatic test_back_to_back();
      out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         drive_word(6'h10 + 6'(i % 5), 5'(i), 5'(i + 1), $urandom, 48'h500 + 48'(i));
         if (i > 0) begin
            act = sample_head();
            checks++;
            if (out_valid !== 1 || exp_q.size() == 0 || act !== exp_q[0]) begin errors++; $display("FAIL b2b_%0d valid=%0b got %h", i, out_valid, act); end
            $display("b2b %0d: opcode=%h pc1=%h", i, opcode, pc1_out);
         end
         tick();
      end
      in_valid = 0;
      tick();
      checks++; if (count !== 0) begin errors++; $display("FAIL b2b_empty count=%0d want 0", count); end
   endtask

   task automatic test_illegal_and_reset();
      exp_t e;
      out_ready = 0;
      drive_word(6'h3F, 5'd1, 5'd2, 32'h1234, 48'h600);
      e = cur_exp;
      tick();
      checks++; if (illegal !== 1 || flagsDECO !== 0 || flagsALU !== 0 || flagsMEM !== 0 || flagsWB !== 2'b01) begin
         errors++; $display("FAIL illegal_flags ill=%0b deco=%0b alu=%0d mem=%b wb=%b want 1 0 0 000 01", illegal, flagsDECO, flagsALU, flagsMEM, flagsWB);
      end
      act = sample_head();
      checks++; if (act !== e) begin errors++; $display("FAIL illegal_head got %h want %h", act, e); end
      $display("illegal: opcode=%h illegal=%0b", opcode, illegal);
      drive_word(6'h21, 5'd0, 5'd0, 32'h0, 48'h601);
      tick();
      #2 rst_n = 0;
      #1;
      checks++; if (out_valid !== 0 || count !== 0 || in_ready !== 1) begin
         errors++; $display("FAIL async_reset valid=%0b count=%0d ready=%0b want 0 0 1", out_valid, count, in_ready);
      end
      $display("async reset: out_valid=%0b count=%0d", out_valid, count);
      exp_q.delete();
      in_valid = 0;
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 0 || flagsWB !== 2'b01) begin errors++; $display("FAIL post_reset valid=%0b wb=%b want 0 01", out_valid, flagsWB); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_full_pushpop();
      test_flush();
      test_back_to_back();
      test_illegal_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
